aes_dec_top: RTL and testbench

AES_DEC_TOP -- requirements
Module: aes_dec_top

---
 rtl/aes_pkg.sv | 78 +++++++
 rtl/aes_inv_round.sv | 48 ++++
 rtl/aes_dec_top.sv | 123 ++++++++++++
 tb/tb_aes_dec_top.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state encoding, round constants and the
// GF(2^8) helpers behind the forward and inverse S-boxes.
package aes_pkg;

  typedef logic [1:0] aes_state_t;

  localparam aes_state_t ST_IDLE  = 2'd0;
  localparam aes_state_t ST_KEXP  = 2'd1;
  localparam aes_state_t ST_ROUND = 2'd2;
  localparam aes_state_t ST_DONE  = 2'd3;

  // Round constant for key-schedule step idx (idx 0 -> first expansion).
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xtime(x);
    end
    return r;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
    return ginv(b);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when last).
// Byte i of a 128-bit word sits at bits [127-8i -: 8]; state[r][c] = byte r+4c.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rkey,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [127:0] sub_s;
  logic [127:0] ark_s;
  logic [127:0] mix_s;

  // Inverse shift rows (row r rotates right by r) fused with the inverse S-box.
  always_comb begin
    sub_s = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub_s[127 - 8*(r + 4*c) -: 8] =
          inv_sbox(state_in[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8]);
      end
    end
  end

  assign ark_s = sub_s ^ rkey;

  // Inverse mix columns on each 4-byte column.
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    mix_s = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = ark_s[127 - 8*(4*c)     -: 8];
      a1 = ark_s[127 - 8*(4*c + 1) -: 8];
      a2 = ark_s[127 - 8*(4*c + 2) -: 8];
      a3 = ark_s[127 - 8*(4*c + 3) -: 8];
      mix_s[127 - 8*(4*c)     -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      mix_s[127 - 8*(4*c + 1) -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      mix_s[127 - 8*(4*c + 2) -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      mix_s[127 - 8*(4*c + 3) -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
  end

  assign state_out = last ? ark_s : mix_s;

endmodule

// File: rtl/aes_dec_top.sv
// Iterative AES-128 decryptor, one round per clock.
// The round key is walked forward to rk10 during KEXP, then backward one step
// per ROUND cycle, so only the current round key is ever stored.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for ciphertext + key
//   KEXP  | 10 forward key-expansion steps; last step loads ct ^ rk10
//   ROUND | 10 inverse rounds, key un-expanded alongside; last has no InvMixColumns
//   DONE  | plaintext presented on pt until out_ready
module aes_dec_top
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt,
  output logic         busy
);

  localparam logic [3:0] LAST_CNT = 4'(NR - 1);

  aes_state_t   fsm;
  logic [3:0]   cnt;
  logic [127:0] st;
  logic [127:0] rk;
  logic [127:0] rk_fwd;
  logic [127:0] rk_inv;
  logic [127:0] round_out;
  logic         last_step;

  function automatic logic [127:0] fwd_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one expansion step: recover the previous words from the next ones,
  // last word first since it feeds the SubWord term.
  function automatic logic [127:0] inv_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3, w0, w1, w2, w3;
    {n0, n1, n2, n3} = k;
    w3 = n3 ^ n2;
    w2 = n2 ^ n1;
    w1 = n1 ^ n0;
    w0 = n0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  assign last_step = (cnt == LAST_CNT);
  assign rk_fwd    = fwd_expand(rk, rcon(cnt));
  assign rk_inv    = inv_expand(rk, rcon(LAST_CNT - cnt));

  aes_inv_round u_round (
    .state_in  (st),
    .rkey      (rk_inv),
    .last      (last_step),
    .state_out (round_out)
  );

  // Sequencer: state, round counter, data state and current round key.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm <= ST_IDLE;
      cnt <= 4'd0;
      st  <= '0;
      rk  <= '0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (in_valid) begin
            st  <= ct;
            rk  <= key;
            cnt <= 4'd0;
            fsm <= ST_KEXP;
          end
        end
        ST_KEXP: begin
          rk <= rk_fwd;
          if (last_step) begin
            st  <= st ^ rk_fwd;
            cnt <= 4'd0;
            fsm <= ST_ROUND;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_ROUND: begin
          rk <= rk_inv;
          st <= round_out;
          if (last_step) begin
            cnt <= 4'd0;
            fsm <= ST_DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) fsm <= ST_IDLE;
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

  // in_ready is gated by rst so it reads 0 for the whole reset pulse.
  assign in_ready  = rst && (fsm == ST_IDLE);
  assign out_valid = (fsm == ST_DONE);
  assign busy      = (fsm != ST_IDLE);
  assign pt        = out_valid ? st : '0;

endmodule

// File: tb/tb_aes_dec_top.sv
// Testbench for aes_dec_top: known-answer vectors, back-pressure, busy-ignore,
// mid-operation reset and a random round trip through a reference encryptor.
module tb_aes_dec_top;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] ct = '0;
  logic [127:0] key = '0;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [127:0] pt;

  int checks = 0;
  int errors = 0;
  logic [127:0] sb_q [$];
  logic [7:0]   sbt [256];

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           hold;
  } vec_t;

  vec_t vecs [4];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

  always #5 clk = ~clk;

  aes_dec_top #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct        (ct),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt        (pt),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  // Reference S-box: brute-force inverse search, then the bitwise affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbt[a] = s;
    end
  endtask

  // Reference AES-128 encryptor with a fully stored key schedule.
  function automatic logic [127:0] encrypt(input logic [127:0] k, input logic [127:0] p);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]], sbt[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++)
          t[j + 4*c] = sbt[s[j + 4*((c + j) % 4)]];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          s[4*c]   = gm(8'h02, a0) ^ gm(8'h03, a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(8'h02, a1) ^ gm(8'h03, a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(8'h02, a2) ^ gm(8'h03, a3);
          s[4*c+3] = gm(8'h03, a0) ^ a1 ^ a2 ^ gm(8'h02, a3);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31 - 8*(i%4) -: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  // One decryption. hold < 0: out_ready high from acceptance; otherwise
  // out_ready low for the first `hold` out_valid cycles. glitch_at / rst_at
  // (cycles after the accepting edge, -1 = off) inject busy-time stimulus
  // or a mid-operation reset.
  task automatic run_op(input logic [127:0] k, input logic [127:0] c, input logic [127:0] exp,
                        input int hold, input int glitch_at, input int rst_at, input string tag);
    int n;
    int lat;
    logic [127:0] e;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, " in_ready idle"}, 128'(in_ready), 128'd1);
    if (!in_ready) return;
    key = k;
    ct = c;
    in_valid = 1'b1;
    out_ready = (hold < 0);
    sb_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    ct = rand128();
    key = rand128();
    check({tag, " busy after accept"}, 128'({busy, in_ready}), 128'b10);
    lat = 0;
    while (1'b1) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == glitch_at) begin
        in_valid = 1'b1;
        ct = rand128();
        key = rand128();
      end
      if (glitch_at >= 0 && lat == glitch_at + 3) in_valid = 1'b0;
      if (lat == rst_at) begin
        rst = 1'b0;
        #1;
        check({tag, " reset flags"}, 128'({in_ready, out_valid, busy}), 128'd0);
        check({tag, " reset pt"}, pt, 128'd0);
        e = sb_q.pop_back();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check({tag, " in_ready after reset"}, 128'(in_ready), 128'd1);
        return;
      end
      if (out_valid || lat >= 40) break;
    end
    in_valid = 1'b0;
    check({tag, " latency"}, 128'(lat), 128'd20);
    if (!out_valid) begin
      e = sb_q.pop_front();
      out_ready = 1'b0;
      return;
    end
    check({tag, " done flags"}, 128'({out_valid, in_ready, busy}), 128'b101);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, " held out_valid"}, 128'(out_valid), 128'd1);
      check({tag, " held pt"}, pt, exp);
    end
    out_ready = 1'b1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected output: got %h expected none", tag, pt);
    end else begin
      e = sb_q.pop_front();
      check({tag, " pt"}, pt, e);
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " after transfer"}, 128'({out_valid, in_ready}), 128'b01);
    check({tag, " pt idle zero"}, pt, 128'd0);
  endtask

  initial begin
    int n;
    logic [127:0] rk_r, rp_r, rc_r;
    build_sbox();

    vecs[0] = '{C1_KEY, C1_CT, C1_PT, 0};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734, 2};
    vecs[2] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, -1};
    vecs[3] = '{C1_KEY, C1_CT, C1_PT, 7};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset flags", 128'({in_ready, out_valid, busy}), 128'd0);
    check("reset pt", pt, 128'd0);
    rst = 1'b1;
    @(negedge clk);
    check("in_ready after release", 128'(in_ready), 128'd1);

    for (int i = 0; i < 4; i++)
      run_op(vecs[i].key, vecs[i].ct, vecs[i].pt, vecs[i].hold, -1, -1, $sformatf("vec%0d", i));

    run_op(C1_KEY, C1_CT, C1_PT, 0, 5, -1, "busy_ignore");
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("no second result", 128'(n), 128'd0);
    check("scoreboard empty", 128'(sb_q.size()), 128'd0);

    run_op(C1_KEY, C1_CT, C1_PT, 0, -1, 12, "reset_mid");
    run_op(C1_KEY, C1_CT, C1_PT, 0, -1, -1, "after_reset");

    for (int i = 0; i < 1000; i++) begin
      rk_r = rand128();
      rp_r = rand128();
      rc_r = encrypt(rk_r, rp_r);
      run_op(rk_r, rc_r, rp_r, int'($urandom_range(0, 3)) - 1, -1, -1, $sformatf("rt%0d", i));
    end

    check("final scoreboard empty", 128'(sb_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
